// File: rtl/timer_pkg.sv
// Shared definitions for the timer sequence monitor: sample width and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_pkg;

  localparam int TIMER_W = 16;

  // IDLE : no reference value yet
  // TRACK: a sample was seen last cycle
  // GAP  : samples paused, expected value held
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/timer_cap_fifo.sv
// Synchronous capture FIFO with show-ahead head and sticky overflow flag.
// Latency: a pushed word is visible at head_o / level_o one cycle after the push.
// Backpressure: pop only when non-empty; a push into a full FIFO is dropped unless a
//   pop happens in the same cycle.
// Ports: clk, rst (async high); push_i/push_dat_i write side; pop_i read request;
//   head_o show-ahead head (0 when empty); empty_o, full_o, level_o, overflow_o status.
module timer_cap_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DW-1:0]              push_dat_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              head_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));

  // A pop frees the slot a full-FIFO push needs, so both may complete together.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (push_i && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_dat_i;
  end

  assign head_o     = empty_o ? '0 : mem_q[rd_q];
  assign level_o    = level_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/timer_monitor.sv
// Timer sample sequence checker with on-demand sample capture into a FIFO.
// Latency: seq_err/err_count/run_len one cycle after the sample; capture visible next cycle.
// Backpressure: none on samples; captures beyond FIFO space are dropped and flagged.
// Ports: clk, rst (async high); t_valid/t_data samples; cap_req capture request;
//   cap_ready consumer accept; seq_err, err_count, run_len checker status;
//   cap_valid/cap_data/cap_level/cap_overflow capture FIFO side.
module timer_monitor
  import timer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            t_valid,
  input  logic [TIMER_W-1:0]              t_data,
  input  logic                            cap_req,
  input  logic                            cap_ready,
  output logic                            seq_err,
  output logic [ERR_W-1:0]                err_count,
  output logic [15:0]                     run_len,
  output logic                            cap_valid,
  output logic [TIMER_W-1:0]              cap_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] cap_level,
  output logic                            cap_overflow
);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] exp_q, exp_d;
  logic [15:0]        run_q, run_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               seq_err_q, seq_err_d;
  logic               pend_q, pend_d;
  logic               cap_push;
  logic               fifo_empty;
  logic               fifo_full;

  // ---------------- sequence checker FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      exp_q     <= '0;
      run_q     <= '0;
      err_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      run_q     <= run_d;
      err_q     <= err_d;
      seq_err_q <= seq_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    run_d     = run_q;
    err_d     = err_q;
    seq_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        // First sample only establishes the reference.
        if (t_valid) begin
          exp_d   = t_data + 1'b1;
          run_d   = 16'd1;
          state_d = TRACK;
        end
      end
      TRACK, GAP: begin
        if (t_valid) begin
          state_d = TRACK;
          if (t_data == exp_q) begin
            // Natural 16-bit wrap makes 0xFFFF -> 0x0000 in sequence.
            exp_d = exp_q + 1'b1;
            if (run_q != 16'hFFFF) run_d = run_q + 1'b1;
          end else begin
            seq_err_d = 1'b1;
            if (err_q != '1) err_d = err_q + 1'b1;
            run_d = 16'd1;
            exp_d = t_data + 1'b1;
          end
        end else begin
          state_d = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- capture request ----------------
  // A request waits for the next valid sample; the request cycle itself counts,
  // and repeated requests while waiting collapse into one capture.
  assign cap_push = t_valid && (pend_q || cap_req);
  assign pend_d   = (pend_q || cap_req) && !t_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end

  timer_cap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (TIMER_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (cap_push),
    .push_dat_i (t_data),
    .pop_i      (cap_ready),
    .head_o     (cap_data),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .level_o    (cap_level),
    .overflow_o (cap_overflow)
  );

  assign cap_valid = !fifo_empty;
  assign seq_err   = seq_err_q;
  assign err_count = err_q;
  assign run_len   = run_q;

  // Full status is exposed by the FIFO for completeness; the top relies on level.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/timer_monitor.md
TIMER_MONITOR -- requirements
Module: timer_monitor

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, capture FIFO entries, power of two, at least 2.
REQ-002 The block SHALL have parameter ERR_W, default 8, width of the error counter.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port t_valid  input  1  timer sample valid.
REQ-006 The block SHALL have port t_data  input  16  timer sample value.
REQ-007 The block SHALL have port cap_req  input  1  one-cycle capture request.
REQ-008 The block SHALL have port cap_ready  input  1  consumer accepts the FIFO head.
REQ-009 The block SHALL have port seq_err  output  1  one-cycle pulse on a sequence mismatch.
REQ-010 The block SHALL have port err_count  output  ERR_W  saturating mismatch count.
REQ-011 The block SHALL have port run_len  output  16  consecutive in-sequence samples, saturating.
REQ-012 The block SHALL have port cap_valid  output  1  FIFO non-empty.
REQ-013 The block SHALL have port cap_data  output  16  FIFO head, show-ahead.
REQ-014 The block SHALL have port cap_level  output  clog2(FIFO_DEPTH+1)  FIFO occupancy.
REQ-015 The block SHALL have port cap_overflow  output  1  sticky flag: a capture was dropped.

Function
REQ-016 The FSM SHALL have states IDLE (no reference), TRACK (t_valid seen last cycle) and GAP (t_valid low, expected value held).
REQ-017 In IDLE, a t_valid sample SHALL be accepted unchecked, set expected to t_data+1 (mod 2^16) and set run_len=1, and the FSM SHALL go to TRACK.
REQ-018 In TRACK or GAP, a t_valid sample equal to expected SHALL advance expected by 1 and increment run_len, saturating at 0xFFFF.
REQ-019 A mismatching sample SHALL pulse seq_err on the next cycle, increment err_count (saturating at 2^ERR_W-1), set run_len=1 and resynchronise expected to t_data+1.
REQ-020 Wrap-around 0xFFFF->0x0000 SHALL be treated as in sequence.
REQ-021 t_valid low in TRACK SHALL move the FSM to GAP with expected unchanged, and t_valid high in GAP SHALL be checked and return the FSM to TRACK.
REQ-022 seq_err, err_count and run_len SHALL be registered and reflect a sample one cycle after it is presented.
REQ-023 cap_req SHALL set a pending flag, and the first cycle with t_valid while the flag is set (including the cycle of cap_req itself) SHALL push t_data and clear the flag.
REQ-024 cap_req arriving while a capture is already pending SHALL merge into a single capture.
REQ-025 Pop SHALL occur when cap_valid and cap_ready are both high, and cap_data SHALL present the next entry on the following cycle.
REQ-026 A push when full without a same-cycle pop SHALL be dropped and SHALL set cap_overflow, which stays set until reset.
REQ-027 A push and pop in the same cycle SHALL both complete, including when the FIFO is full, with cap_level unchanged.
REQ-028 cap_ready while empty SHALL have no effect, and cap_level SHALL update one cycle after a push or pop.

Reset
REQ-029 rst SHALL asynchronously force: state IDLE, expected 0, pending flag 0, FIFO empty, seq_err 0, err_count 0, run_len 0, cap_valid 0, cap_data 0, cap_level 0, cap_overflow 0.
REQ-030 Reset mid-stream or mid-capture SHALL discard all history, and the first sample after release SHALL be accepted per REQ-017.

Structure
REQ-031 Shared package timer_pkg SHALL hold TIMER_W=16 and the FSM state enum (IDLE, TRACK, GAP).
REQ-032 The capture FIFO SHALL be a sub-module timer_cap_fifo (sync FIFO with push, pop, full, empty, level, show-ahead head).
REQ-033 Sequence checking, capture logic and the FSM SHALL live in timer_monitor.

Verification
REQ-034 Samples 0,1,2,3 on consecutive cycles after reset -> seq_err never pulses; run_len=4; err_count=0.
REQ-035 Samples 0xFFFE, 0xFFFF, 0x0000 -> no seq_err; run_len=3.
REQ-036 Samples 5,6, gap of 3 cycles, then 7,9,10 -> one seq_err pulse, the cycle after 9; err_count=1; run_len=2 after 10.
REQ-037 cap_req with t_valid low, then t_valid with 0x0042 two cycles later -> one entry 0x0042; cap_valid=1; cap_level=1.
REQ-038 Five captures with cap_ready=0 (DEPTH 4) -> cap_level=4, cap_overflow=1, entries are the first four values; then cap_ready=1 -> they drain in order.
REQ-039 Reset asserted with FIFO level 3 and err_count 2 -> all outputs zero immediately; first sample 0x1234 after release -> no seq_err.
